// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: grant FSM states and requester id.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam int DEFAULT_MAX_LOCK = 16;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data-memory arbiter: access request plus registered read response.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              valid;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output valid, we, lock, addr, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, we, lock, addr, wdata,
    output ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, on conflict the one not served last wins.
module rr_pick2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == 1'b0) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the CPU port (req0) and the debug/DMA
// port (req1): combinational round-robin grant, bounded lock, registered read response.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = DEFAULT_MAX_LOCK
) (
  input  logic              CLK,
  input  logic              RST_N,
  data_mem_arbiter_if.slave req0,
  data_mem_arbiter_if.slave req1,
  output logic              lock_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_op,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [7:0] CNT_LAST = 8'(MAX_LOCK - 1);

  arb_state_t        state;
  req_id_t           last;
  logic [7:0]        lock_cnt;
  logic [1:0]        valid;
  logic [1:0]        pick;
  logic [1:0]        gnt;
  logic              rd0;
  logic              rd1;
  logic              rsp0_vld_p1;
  logic              rsp1_vld_p1;
  logic [DATA_W-1:0] rsp0_data_p1;
  logic [DATA_W-1:0] rsp1_data_p1;

  assign valid = {req1.valid, req0.valid};

  rr_pick2 u_pick (
    .valid (valid),
    .last  (last),
    .gnt   (pick)
  );

  // Grant is combinational; reset forces it low so the memory is never written in reset.
  always_comb begin
    gnt = 2'b00;
    case (state)
      FREE:    gnt = pick;
      OWN0:    gnt = {1'b0, req0.valid};
      OWN1:    gnt = {req1.valid, 1'b0};
      default: gnt = 2'b00;
    endcase
    if (!RST_N) gnt = 2'b00;
  end

  assign req0.ready = gnt[0];
  assign req1.ready = gnt[1];
  assign mem_addr   = gnt[1] ? req1.addr  : req0.addr;
  assign mem_wdata  = gnt[1] ? req1.wdata : req0.wdata;
  assign mem_op     = (gnt[0] & req0.we) | (gnt[1] & req1.we);
  assign rd0        = gnt[0] & ~req0.we;
  assign rd1        = gnt[1] & ~req1.we;

  // p0 -> p1: accept cycle to response cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= FREE;
      last         <= 1'b1;
      lock_cnt     <= 8'd0;
      lock_err     <= 1'b0;
      rsp0_vld_p1  <= 1'b0;
      rsp1_vld_p1  <= 1'b0;
      rsp0_data_p1 <= '0;
      rsp1_data_p1 <= '0;
    end else begin
      lock_err    <= 1'b0;
      rsp0_vld_p1 <= rd0;
      rsp1_vld_p1 <= rd1;
      if (rd0) rsp0_data_p1 <= mem_rdata;
      if (rd1) rsp1_data_p1 <= mem_rdata;
      if (gnt[0])      last <= 1'b0;
      else if (gnt[1]) last <= 1'b1;

      case (state)
        FREE: begin
          lock_cnt <= 8'd0;
          if (gnt[0] && req0.lock)      state <= OWN0;
          else if (gnt[1] && req1.lock) state <= OWN1;
        end
        OWN0: begin
          lock_cnt <= lock_cnt + 8'd1;
          if (!req0.lock) begin
            state <= FREE;
          end else if (lock_cnt == CNT_LAST) begin
            // Owner overstayed: the final cycle was served, now hand the memory back.
            state    <= FREE;
            lock_err <= 1'b1;
            last     <= 1'b0;
          end
        end
        OWN1: begin
          lock_cnt <= lock_cnt + 8'd1;
          if (!req1.lock) begin
            state <= FREE;
          end else if (lock_cnt == CNT_LAST) begin
            state    <= FREE;
            lock_err <= 1'b1;
            last     <= 1'b1;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

  assign req0.rsp_valid = rsp0_vld_p1;
  assign req1.rsp_valid = rsp1_vld_p1;
  assign req0.rsp_rdata = rsp0_data_p1;
  assign req1.rsp_rdata = rsp1_data_p1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 256x8 memory model behind it (MAX_LOCK=4).
module tb_data_mem_arbiter;
  logic       clk;
  logic       rst_n;
  logic       lock_err;
  logic       mem_op;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] mem [256];
  logic       pl_en;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;
  int         total = 0;
  int         bad = 0;

  data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) r0 ();
  data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) r1 ();

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(4)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .req0      (r0),
    .req1      (r1),
    .lock_err  (lock_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_op    (mem_op),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model; preload port only used while the arbiter is in reset.
  always @(posedge clk) begin
    if (mem_op)     mem[mem_addr] <= mem_wdata;
    else if (pl_en) mem[pl_addr]  <= pl_data;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0.valid = 0; r0.we = 0; r0.lock = 0; r0.addr = 8'h00; r0.wdata = 8'h00;
    r1.valid = 0; r1.we = 0; r1.lock = 0; r1.addr = 8'h00; r1.wdata = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    r0.valid = 1; r0.we = 1; r1.valid = 1; r1.we = 1;
    pl_en = 1;
    for (int k = 0; k < 256; k++) begin
      pl_addr = 8'(k);
      pl_data = 8'(k) ^ 8'h5A;
      step();
    end
    pl_en = 0;
    @(negedge clk);
    total++; if (r0.ready !== 1'b0) begin $display("FAIL reset ready0 got %b want 0", r0.ready); bad++; end
    total++; if (r1.ready !== 1'b0) begin $display("FAIL reset ready1 got %b want 0", r1.ready); bad++; end
    total++; if (mem_op !== 1'b0) begin $display("FAIL reset mem_op got %b want 0", mem_op); bad++; end
    total++; if (r0.rsp_valid !== 1'b0 || r1.rsp_valid !== 1'b0) begin
      $display("FAIL reset rsp_valid got %b%b want 00", r1.rsp_valid, r0.rsp_valid); bad++; end
    total++; if (r0.rsp_rdata !== 8'h00 || r1.rsp_rdata !== 8'h00) begin
      $display("FAIL reset rsp_rdata got %h/%h want 00/00", r0.rsp_rdata, r1.rsp_rdata); bad++; end
    total++; if (lock_err !== 1'b0) begin $display("FAIL reset lock_err got %b want 0", lock_err); bad++; end
    step();
    rst_n = 1;
    idle_inputs();
  endtask

  task automatic test_contention();
    logic e0;
    logic p0;
    r0.valid = 1; r0.addr = 8'h30;
    r1.valid = 1; r1.addr = 8'h31;
    for (int i = 0; i < 6; i++) begin
      e0 = (i % 2 == 0);
      p0 = (i % 2 == 1);
      @(negedge clk);
      total++; if (r0.ready !== e0 || r1.ready !== !e0) begin
        $display("FAIL contention grant cyc %0d got %b%b want %b%b", i, r1.ready, r0.ready, !e0, e0); bad++; end
      total++; if (mem_addr !== (e0 ? 8'h30 : 8'h31)) begin
        $display("FAIL contention mem_addr cyc %0d got %h want %h", i, mem_addr, e0 ? 8'h30 : 8'h31); bad++; end
      if (i > 0) begin
        total++; if (r0.rsp_valid !== p0 || r1.rsp_valid !== !p0) begin
          $display("FAIL contention rsp cyc %0d got %b%b want %b%b", i, r1.rsp_valid, r0.rsp_valid, !p0, p0); bad++; end
      end
      step();
    end
    idle_inputs();
    @(negedge clk);
    total++; if (r1.rsp_valid !== 1'b1 || r1.rsp_rdata !== 8'h6B) begin
      $display("FAIL contention last rsp1 got %b/%h want 1/6b", r1.rsp_valid, r1.rsp_rdata); bad++; end
    total++; if (r0.rsp_valid !== 1'b0 || r0.rsp_rdata !== 8'h6A) begin
      $display("FAIL contention rsp0 hold got %b/%h want 0/6a", r0.rsp_valid, r0.rsp_rdata); bad++; end
    step();
  endtask

  task automatic test_read_resp();
    r0.valid = 1; r0.we = 1; r0.addr = 8'h10; r0.wdata = 8'hA5;
    @(negedge clk);
    total++; if (r0.ready !== 1'b1 || mem_op !== 1'b1 || mem_wdata !== 8'hA5) begin
      $display("FAIL rdresp write got ready=%b op=%b wdata=%h want 1 1 a5", r0.ready, mem_op, mem_wdata); bad++; end
    step();
    r0.we = 0;
    @(negedge clk);
    total++; if (r0.ready !== 1'b1 || mem_op !== 1'b0) begin
      $display("FAIL rdresp read got ready=%b op=%b want 1 0", r0.ready, mem_op); bad++; end
    total++; if (r0.rsp_valid !== 1'b0) begin $display("FAIL rdresp write_no_rsp got %b want 0", r0.rsp_valid); bad++; end
    step();
    idle_inputs();
    @(negedge clk);
    total++; if (r0.rsp_valid !== 1'b1 || r0.rsp_rdata !== 8'hA5) begin
      $display("FAIL rdresp data got %b/%h want 1/a5", r0.rsp_valid, r0.rsp_rdata); bad++; end
    total++; if (mem_op !== 1'b0) begin $display("FAIL rdresp idle mem_op got %b want 0", mem_op); bad++; end
    step();
    @(negedge clk);
    total++; if (r0.rsp_valid !== 1'b0 || r0.rsp_rdata !== 8'hA5) begin
      $display("FAIL rdresp pulse/hold got %b/%h want 0/a5", r0.rsp_valid, r0.rsp_rdata); bad++; end
    step();
  endtask

  task automatic test_lock();
    r0.valid = 1; r0.addr = 8'h40;
    r1.valid = 1; r1.lock = 1; r1.addr = 8'h20;
    @(negedge clk);
    total++; if (r1.ready !== 1'b1 || r0.ready !== 1'b0) begin
      $display("FAIL lock take got %b%b want 10", r1.ready, r0.ready); bad++; end
    step();
    r1.valid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (r0.ready !== 1'b0 || r1.ready !== 1'b0 || mem_op !== 1'b0) begin
        $display("FAIL lock hold cyc %0d got r0=%b r1=%b op=%b want 0 0 0", i, r0.ready, r1.ready, mem_op); bad++; end
      if (i == 0) begin
        total++; if (r1.rsp_valid !== 1'b1 || r1.rsp_rdata !== 8'h7A) begin
          $display("FAIL lock rsp1 got %b/%h want 1/7a", r1.rsp_valid, r1.rsp_rdata); bad++; end
      end
      step();
    end
    r1.valid = 1; r1.we = 1; r1.lock = 0; r1.wdata = 8'h21;
    @(negedge clk);
    total++; if (r1.ready !== 1'b1 || r0.ready !== 1'b0 || mem_op !== 1'b1 || mem_wdata !== 8'h21) begin
      $display("FAIL lock unlock_write got r1=%b r0=%b op=%b wd=%h want 1 0 1 21", r1.ready, r0.ready, mem_op, mem_wdata); bad++; end
    step();
    r1.valid = 0; r1.we = 0;
    @(negedge clk);
    total++; if (r0.ready !== 1'b1 || mem_addr !== 8'h40) begin
      $display("FAIL lock free got r0=%b addr=%h want 1 40", r0.ready, mem_addr); bad++; end
    total++; if (mem[8'h20] !== 8'h21) begin $display("FAIL lock memory got %h want 21", mem[8'h20]); bad++; end
    total++; if (lock_err !== 1'b0) begin $display("FAIL lock lock_err got %b want 0", lock_err); bad++; end
    step();
    idle_inputs();
    @(negedge clk);
    total++; if (r0.rsp_valid !== 1'b1 || r0.rsp_rdata !== 8'h1A) begin
      $display("FAIL lock rsp0 got %b/%h want 1/1a", r0.rsp_valid, r0.rsp_rdata); bad++; end
    step();
  endtask

  task automatic test_forced_release();
    r0.valid = 1; r0.addr = 8'h51;
    r1.valid = 1; r1.lock = 1; r1.addr = 8'h50;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (r1.ready !== 1'b1 || r0.ready !== 1'b0 || lock_err !== 1'b0) begin
        $display("FAIL force hold cyc %0d got r1=%b r0=%b err=%b want 1 0 0", i, r1.ready, r0.ready, lock_err); bad++; end
      if (i == 1) begin
        total++; if (r1.rsp_rdata !== 8'h0A) begin $display("FAIL force rsp1 got %h want 0a", r1.rsp_rdata); bad++; end
      end
      step();
    end
    @(negedge clk);
    total++; if (lock_err !== 1'b1) begin $display("FAIL force lock_err got %b want 1", lock_err); bad++; end
    total++; if (r0.ready !== 1'b1 || r1.ready !== 1'b0) begin
      $display("FAIL force handover got %b%b want 01", r1.ready, r0.ready); bad++; end
    step();
    idle_inputs();
    @(negedge clk);
    total++; if (lock_err !== 1'b0) begin $display("FAIL force err_pulse got %b want 0", lock_err); bad++; end
    total++; if (r0.rsp_valid !== 1'b1 || r0.rsp_rdata !== 8'h0B) begin
      $display("FAIL force rsp0 got %b/%h want 1/0b", r0.rsp_valid, r0.rsp_rdata); bad++; end
    step();
  endtask

  task automatic test_reset_mid_lock();
    r0.valid = 1; r0.lock = 1; r0.addr = 8'h60;
    step();
    r1.valid = 1; r1.addr = 8'h61;
    @(negedge clk);
    total++; if (r0.ready !== 1'b1 || r1.ready !== 1'b0) begin
      $display("FAIL midlock own0 got %b%b want 01", r1.ready, r0.ready); bad++; end
    step();
    r0.we = 1; r0.wdata = 8'hEE;
    #1;
    total++; if (r0.ready !== 1'b1 || mem_op !== 1'b1 || r0.rsp_valid !== 1'b1) begin
      $display("FAIL midlock pre got ready=%b op=%b rsp=%b want 1 1 1", r0.ready, mem_op, r0.rsp_valid); bad++; end
    #1;
    rst_n = 0;
    #1;
    total++; if (r0.ready !== 1'b0 || r1.ready !== 1'b0 || mem_op !== 1'b0) begin
      $display("FAIL midlock async got r0=%b r1=%b op=%b want 0 0 0", r0.ready, r1.ready, mem_op); bad++; end
    total++; if (r0.rsp_valid !== 1'b0 || r1.rsp_valid !== 1'b0 || lock_err !== 1'b0) begin
      $display("FAIL midlock regs got rsp=%b%b err=%b want 00 0", r1.rsp_valid, r0.rsp_valid, lock_err); bad++; end
    step();
    rst_n = 1;
    r0.we = 0; r0.lock = 0;
    @(negedge clk);
    total++; if (r0.ready !== 1'b1 || r1.ready !== 1'b0 || mem_op !== 1'b0) begin
      $display("FAIL midlock first_conflict got %b%b op=%b want 01 0", r1.ready, r0.ready, mem_op); bad++; end
    step();
    idle_inputs();
    @(negedge clk);
    total++; if (r0.rsp_valid !== 1'b1 || r0.rsp_rdata !== 8'h3A || lock_err !== 1'b0) begin
      $display("FAIL midlock rsp got %b/%h err=%b want 1/3a 0", r0.rsp_valid, r0.rsp_rdata, lock_err); bad++; end
    step();
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (mem_op !== 1'b0 || r0.rsp_valid !== 1'b0 || r1.rsp_valid !== 1'b0) begin
        $display("FAIL idle cyc %0d got op=%b rsp=%b%b want 0 00", i, mem_op, r1.rsp_valid, r0.rsp_valid); bad++; end
      step();
    end
    total++; if (mem[8'h10] !== 8'hA5 || mem[8'h20] !== 8'h21 || mem[8'h60] !== 8'h3A || mem[8'h77] !== 8'h2D) begin
      $display("FAIL idle memory got %h %h %h %h want a5 21 3a 2d", mem[8'h10], mem[8'h20], mem[8'h60], mem[8'h77]); bad++; end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_read_resp();
    test_lock();
    test_forced_release();
    test_reset_mid_lock();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-port 256x8 data memory between two requesters: port 0 is the CPU load/store stage, port 1 is the debug/DMA engine. It grants at most one access per cycle with round-robin fairness, drives the memory's address, write-data and write-enable pins, and returns read data on a registered response channel. A bounded lock lets one requester hold the memory for an atomic read-modify-write sequence.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- MAX_LOCK, 16, maximum cycles a lock may be held before forced release (2..255)

- CLK  in  1  clock; all registers update on posedge
- RST_N  in  1  reset, asynchronous assert, active-low
- reqN_valid  in  1  requester N (N=0,1) has an access pending
- reqN_we  in  1  1 = write, 0 = read
- reqN_lock  in  1  request or continue exclusive ownership
- reqN_addr  in  ADDR_W  access address
- reqN_wdata  in  DATA_W  write data
- reqN_ready  out  1  access accepted this cycle (combinational grant)
- rspN_valid  out  1  read data valid, one-cycle pulse
- rspN_rdata  out  DATA_W  read data, held until the next read response
- lock_err  out  1  one-cycle pulse when a lock is force-released
- mem_addr  out  ADDR_W  to the memory's address pin
- mem_wdata  out  DATA_W  to the memory's data-in pin
- mem_op  out  1  to the memory's write enable (1 = write)
- mem_rdata  in  DATA_W  from the memory's combinational read output

## Operation
- Transfer: reqN_valid & reqN_ready in the same cycle. The requester holds valid, we, addr and wdata stable until ready is high.
- Grant state machine, states FREE, OWN0 and OWN1:
  - FREE:
    - Only one valid: that requester is granted.
    - Both valid: the requester other than `last` is granted.
    - Granted transfer with lock=1: go to OWNn and clear lock_cnt.
  - OWNn:
    - Only requester n can be granted (when valid). The other requester's ready is 0.
    - Requester n deasserts lock while valid: that transfer completes and the state returns to FREE.
    - Requester n deasserts lock while idle: return to FREE immediately.
    - lock_cnt increments every cycle in OWNn.
    - lock_cnt == MAX_LOCK-1: the current cycle is still served. Then go to FREE, pulse lock_err, and set last=n.
- `last` is set to the granted id on every transfer.
- Memory drive:
  - mem_addr and mem_wdata come from the granted port.
  - With no grant, mem_addr and mem_wdata come from port 0.
  - mem_op = grant & we. It is 0 whenever there is no grant or RST_N=0.
- Read response: on a granted read, rspN_rdata <= mem_rdata and rspN_valid <= 1 for exactly one cycle. Writes produce no response.
- Reset values: state=FREE, last=1 (port 0 wins the first conflict), lock_cnt=0, rsp0_valid=rsp1_valid=0, rsp0_rdata=rsp1_rdata=0, lock_err=0. reqN_ready and mem_op are 0 while RST_N=0.
- Reset during a lock: ownership is dropped immediately, with no lock_err pulse.

## Timing
- Grant latency: 0 cycles. Ready is combinational from valid, lock and state.
- Read latency: 1 cycle. Data appears in the cycle after acceptance.
- Write latency: the memory updates at the posedge ending the accept cycle.
- A read and a write to the same address in consecutive cycles is safe. A read accepted in the cycle after a write returns the new data.
- Throughput: one transfer per cycle in total, alternating under sustained contention.
- No combinational path from mem_rdata to any output.

## Structure
- Package data_mem_arb_pkg:
  - typedef arb_state_t {FREE, OWN0, OWN1}
  - typedef req_id_t (1 bit)
  - localparam DEFAULT_MAX_LOCK=16
- Sub-module rr_pick2: 2-way round-robin picker. Inputs are valid[1:0] and last; outputs are gnt[1:0]. Purely combinational.
- Top level holds the state machine, lock counter, response registers and memory muxing. Target size is about 200 lines of RTL.
- Bench instantiates the real 256x8 data memory behind the arbiter.

## Test plan
- Read response: port 0 writes 0xA5 to 0x10, then reads 0x10. Expect mem_op=1 in cycle 1 only, and rsp0_valid pulse with rsp0_rdata=0xA5 one cycle after the read is accepted.
- Contention: both ports hold valid reads for 6 cycles after reset. Expect grants 0,1,0,1,0,1, and each rsp pulse the cycle after the matching grant.
- Lock: port 1 performs a locked read of 0x20, two idle cycles, then an unlocked write of 0x21 to 0x20. Expect port 0 held off for all 4 cycles and FREE afterwards. Memory[0x20] = 0x21.
- Forced release (MAX_LOCK=4): port 1 holds lock=1 with valid continuously while port 0 is valid. Expect lock_err pulse after 4 cycles, port 0 granted next, no further port 1 grant that cycle.
- Reset mid-lock: assert RST_N=0 in OWN0, asynchronously between edges. Expect ready=0, mem_op=0 and rsp valids=0 immediately. After release, port 0 wins the first conflict.
- Idle: no valids for 10 cycles. Expect mem_op=0, no rsp pulses, memory contents unchanged.
